cpu_v1_ctrl: RTL and testbench

Multi-cycle control unit for the v1 CPU. It fetches a 32-bit instruction from instruction memory over a req/ack handshake and decodes the RV32I I-type ALU subset (ADDI/XORI/ORI/ANDI) plus LUI. It drives the 3-bit ALU op, operand select, immediate and register-file addresses, then pulses the register write enable. It sits between imem, the register file and the ALU, and produces the op codes the ALU consumes.

---
 rtl/cpu_v1_pkg.sv | 26 ++
 rtl/cpu_v1_decode.sv | 42 ++++
 rtl/cpu_v1_ctrl.sv | 101 ++++++++++
 tb/tb_cpu_v1_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_v1_pkg.sv
// Shared types and constants for the v1 CPU control path and ALU.
package cpu_v1_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_XORI = 3'b100;
  localparam logic [2:0] F3_ORI  = 3'b110;
  localparam logic [2:0] F3_ANDI = 3'b111;

endpackage

// File: rtl/cpu_v1_decode.sv
// Combinational instruction decoder: I-type ALU ops (ADDI/XORI/ORI/ANDI) and LUI.
module cpu_v1_decode
  import cpu_v1_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  alu_op,
  output logic        alu_a_sel,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rd,
  output logic        illegal
);

  always_comb begin
    alu_op    = ALU_PASS;
    alu_a_sel = 1'b0;
    imm       = '0;
    rs1       = instr[19:15];
    rd        = instr[11:7];
    illegal   = 1'b1;
    case (instr[6:0])
      OP_IMM: begin
        imm     = {{20{instr[31]}}, instr[31:20]};
        illegal = 1'b0;
        case (instr[14:12])
          F3_ADDI: alu_op = ALU_ADD;
          F3_XORI: alu_op = ALU_XOR;
          F3_ORI:  alu_op = ALU_OR;
          F3_ANDI: alu_op = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      OP_LUI: begin
        alu_a_sel = 1'b1;
        imm       = {instr[31:12], 12'b0};
        illegal   = 1'b0;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_v1_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control unit for the v1 CPU.
// Optional CPU_V1_ILLEGAL_HALT_EN: illegal instructions halt the core instead of retiring as NOPs.
module cpu_v1_ctrl
  import cpu_v1_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rs1,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        alu_a_sel,
  output logic [2:0]  alu_op,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        halted
);

  state_t      state, state_next;
  logic [31:0] ir;
  logic        illegal_reg;

  logic [2:0]  dec_alu_op;
  logic        dec_alu_a_sel;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rd;
  logic        dec_illegal;

  cpu_v1_decode u_decode (
    .instr     (ir),
    .alu_op    (dec_alu_op),
    .alu_a_sel (dec_alu_a_sel),
    .imm       (dec_imm),
    .rs1       (dec_rs1),
    .rd        (dec_rd),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:  if (imem_ack) state_next = ST_DECODE;
`ifdef CPU_V1_ILLEGAL_HALT_EN
      ST_DECODE: state_next = dec_illegal ? ST_HALT : ST_EXEC;
      ST_HALT:   state_next = ST_HALT;
`else
      ST_DECODE: state_next = ST_EXEC;
`endif
      ST_EXEC:   state_next = ST_WB;
      ST_WB:     state_next = ST_FETCH;
      default:   state_next = ST_FETCH;
    endcase
  end

  // Decoded controls are captured on DECODE exit and held until the next DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      ir          <= '0;
      alu_op      <= ALU_PASS;
      alu_a_sel   <= 1'b0;
      imm         <= '0;
      rs1         <= '0;
      rd          <= '0;
      illegal_reg <= 1'b0;
    end else begin
      if (state == ST_FETCH && imem_ack) ir <= imem_rdata;
      if (state == ST_DECODE) begin
        alu_op      <= dec_alu_op;
        alu_a_sel   <= dec_alu_a_sel;
        imm         <= dec_imm;
        rs1         <= dec_rs1;
        rd          <= dec_rd;
        illegal_reg <= dec_illegal;
      end
      if (state == ST_WB) pc <= pc + 32'd4;
    end
  end

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign rf_we     = (state == ST_WB) && !illegal_reg && (rd != 5'd0);

`ifdef CPU_V1_ILLEGAL_HALT_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_v1_ctrl.sv
// Directed self-checking bench for cpu_v1_ctrl (honours CPU_V1_ILLEGAL_HALT_EN).
module tb_cpu_v1_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [4:0]  rs1;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        alu_a_sel;
  logic [2:0]  alu_op;
  logic        rf_we;
  logic [31:0] pc;
  logic        halted;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc   = 32'h0;

  cpu_v1_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .rs1        (rs1),
    .rd         (rd),
    .imm        (imm),
    .alu_a_sel  (alu_a_sel),
    .alu_op     (alu_op),
    .rf_we      (rf_we),
    .pc         (pc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction; starts and ends 1 time unit after a rising edge in FETCH.
  task automatic run_instr(input logic [31:0] word, input int delay, input bit fields,
                           input logic [2:0] e_op, input logic e_asel, input logic [31:0] e_imm,
                           input logic [4:0] e_rs1, input logic [4:0] e_rd, input logic e_we);
    for (int i = 0; i < delay; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hBAD0_BAD0;
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    tick();
    imem_rdata = 32'hDEAD_BEEF;
    chk("decode_req", 32'(imem_req), 32'd0);
    chk("decode_we", 32'(rf_we), 32'd0);
    tick();
    if (fields) begin
      chk("alu_op", 32'(alu_op), 32'(e_op));
      chk("alu_a_sel", 32'(alu_a_sel), 32'(e_asel));
      chk("imm", imm, e_imm);
      chk("rs1", 32'(rs1), 32'(e_rs1));
      chk("rd", 32'(rd), 32'(e_rd));
    end
    chk("exec_we", 32'(rf_we), 32'd0);
    chk("exec_pc", pc, exp_pc);
    tick();
    imem_ack = 1'b0;
    chk("wb_we", 32'(rf_we), 32'(e_we));
    chk("wb_pc", pc, exp_pc);
    tick();
    exp_pc = exp_pc + 32'd4;
    chk("next_pc", pc, exp_pc);
    chk("next_req", 32'(imem_req), 32'd1);
    chk("next_we", 32'(rf_we), 32'd0);
    chk("halted", 32'(halted), 32'd0);
    if (fields) chk("held_alu_op", 32'(alu_op), 32'(e_op));
    $display("instr word=%h delay=%0d pc_after=%h rf_we_exp=%0d", word, delay, pc, e_we);
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_imm", imm, 32'h0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_rs1", 32'(rs1), 32'd0);
    chk("rst_asel", 32'(alu_a_sel), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_req", 32'(imem_req), 32'd1);
    $display("reset released pc=%h", pc);

    run_instr(32'h0050_0093, 0, 1'b1, 3'b001, 1'b0, 32'h0000_0005, 5'd0, 5'd1, 1'b1);  // ADDI x1,x0,5
    run_instr(32'hFFF0_C113, 0, 1'b1, 3'b010, 1'b0, 32'hFFFF_FFFF, 5'd1, 5'd2, 1'b1);  // XORI x2,x1,-1
    run_instr(32'h1234_51B7, 3, 1'b1, 3'b000, 1'b1, 32'h1234_5000, 5'd8, 5'd3, 1'b1);  // LUI x3,0x12345
    run_instr(32'h0000_0013, 0, 1'b1, 3'b001, 1'b0, 32'h0000_0000, 5'd0, 5'd0, 1'b0);  // ADDI x0,x0,0
    run_instr(32'h7F00_E213, 1, 1'b1, 3'b011, 1'b0, 32'h0000_07F0, 5'd1, 5'd4, 1'b1);  // ORI x4,x1,0x7F0
    run_instr(32'h8001_7293, 0, 1'b1, 3'b100, 1'b0, 32'hFFFF_F800, 5'd2, 5'd5, 1'b1);  // ANDI x5,x2,-2048

    // Reset during WB must suppress the write and return pc to RESET_PC.
    imem_ack   = 1'b1;
    imem_rdata = 32'h0010_0313;  // ADDI x6,x0,1
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    chk("abort_wb_we_before", 32'(rf_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(rf_we), 32'd0);
    chk("abort_pc", pc, 32'h0);
    tick();
    rst_n  = 1'b1;
    exp_pc = 32'h0;
    $display("reset abort in WB pc=%h", pc);
    run_instr(32'h0050_0093, 0, 1'b1, 3'b001, 1'b0, 32'h0000_0005, 5'd0, 5'd1, 1'b1);

`ifdef CPU_V1_ILLEGAL_HALT_EN
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0000;
    tick();
    imem_ack = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_we", 32'(rf_we), 32'd0);
      chk("halt_pc", pc, exp_pc);
      imem_ack = 1'b1;
      tick();
    end
    imem_ack = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("unhalt_pc", pc, 32'h0);
    chk("unhalt_halted", 32'(halted), 32'd0);
    chk("unhalt_req", 32'(imem_req), 32'd1);
    $display("illegal halt then reset pc=%h", pc);
`else
    run_instr(32'h0000_0000, 0, 1'b0, 3'b000, 1'b0, 32'h0, 5'd0, 5'd0, 1'b0);  // all-zero word
    run_instr(32'h0010_9093, 0, 1'b0, 3'b000, 1'b0, 32'h0, 5'd0, 5'd0, 1'b0);  // SLLI: bad funct3
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
